sfd_frame_decoder: RTL
======================

// Module: sfd_frame_decoder
// PURPOSE
//  Frame-based stochastic-to-binary decoder with ready/valid output; receive end for sng streams.
//  Counts ones over a fixed frame of 2^N qualified stream bits, then presents one N-bit estimate.
//  Sits after a stochastic datapath (e.g. sng -> stanh -> sfd_frame_decoder) when a windowed,
//  handshaked estimate is needed instead of a free-running dru value.
//  Unipolar or bipolar coding, selected by parameter.
// PARAMETERS
//  N        10  result width; frame length = 2^N accepted bits
//  BIPOLAR  0   0: unipolar, result = ones; 1: bipolar, result = ones - 2^(N-1), two's complement
// PORTS
//  clk           in   1  rising-edge clock
//  rst           in   1  asynchronous, active-high reset
//  bit_in        in   1  stochastic stream bit
//  bit_valid     in   1  bit_in qualifier; counted only when high and state==ACCUM
//  start         in   1  request a new frame (level-sampled)
//  busy          out  1  high in ACCUM
//  result        out  N  decoded value, stable while result_valid
//  result_valid  out  1  result available
//  result_ready  in   1  consumer accepts result
//  overrun       out  1  sticky: a valid bit arrived while in HOLD (bit dropped)
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, result=0, result_valid=0, overrun=0, counters=0.
//  Counters: samp_cnt N+1 bits (accepted bits), ones_cnt N+1 bits (accepted ones).
//  FSM:
//   IDLE : start=1 -> ACCUM; clear samp_cnt, ones_cnt, overrun. Bits in IDLE ignored, no overrun.
//   ACCUM: each cycle bit_valid=1: samp_cnt++, ones_cnt += bit_in.
//          Accepting bit number 2^N -> HOLD on the same edge; result loaded with the final count.
//          start ignored in ACCUM.
//   HOLD : result_valid=1. result_valid&result_ready -> IDLE, or -> ACCUM (counters cleared)
//          if start=1 that cycle. bit_valid=1 in HOLD sets overrun.
//  Latency: result_valid rises at the edge that accepts the last (2^N-th) bit. Min frame 2^N cycles.
//  Arithmetic: ones_sat = (ones_cnt==2^N) ? 2^N-1 : ones_cnt[N-1:0].
//   Unipolar result = ones_sat, range 0..2^N-1.
//   Bipolar result = ones_sat - 2^(N-1) in N-bit two's complement, range -2^(N-1)..2^(N-1)-1.
//  result/result_valid come straight from registers; result holds until the handshake completes.
//  Back-pressure: HOLD persists indefinitely while result_ready=0; no result is lost.
//  overrun: cleared only by reset or a new start; stays set through HOLD->IDLE.
//  Reset mid-frame: partial counts discarded; next frame starts from 0.
//  bit_valid gaps: do not advance samp_cnt; the frame spans more cycles, same value.
// TESTING
//  N=4, U: start pulse, 16 bits of 1 with valid -> result=15 (saturated), valid at 16th edge.
//  N=4, U: stream 1010... x16 -> result=8; B=1 same stream -> result=0.
//  N=4, BIPOLAR=1: 16 zeros -> result=4'b1000 (-8); 16 ones -> 4'b0111 (+7).
//  N=4: ready=0 for 20 cycles after valid with bit_valid=1 -> result held, overrun=1;
//   ready=1 with start=1 -> next frame starts, overrun=0.
//  N=4: bit_valid=1 every 3rd cycle -> same result as contiguous, result_valid after 46 cycles.
//  N=10: rst pulse at sample 300, then start; sng(A=575) feeds bit_in, bit_valid=1 ->
//   result in 575+/-16 and result_valid exactly 1024 cycles after start.

Source files
------------

// File: rtl/sfd_frame_decoder_if.sv
// Stream-in / result-out bundle for sfd_frame_decoder.
// master drives the stream and consumes the result; slave is the decoder.
interface sfd_frame_decoder_if #(
  parameter int N = 10
);
  logic         bit_in;
  logic         bit_valid;
  logic         start;
  logic         busy;
  logic [N-1:0] result;
  logic         result_valid;
  logic         result_ready;
  logic         overrun;

  modport master (
    output bit_in,
    output bit_valid,
    output start,
    output result_ready,
    input  busy,
    input  result,
    input  result_valid,
    input  overrun
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  start,
    input  result_ready,
    output busy,
    output result,
    output result_valid,
    output overrun
  );
endinterface

// File: rtl/sfd_frame_decoder.sv
// Frame-based stochastic-to-binary decoder: counts ones over 2^N
// accepted stream bits and presents one N-bit estimate via ready/valid.
module sfd_frame_decoder #(
  parameter int N       = 10,
  parameter bit BIPOLAR = 1'b0
) (
  input logic             clk,
  input logic             rst,
  sfd_frame_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [N:0]   FRAME = {1'b1, {N{1'b0}}};
  localparam logic [N-1:0] HALF  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N:0]   ONE   = {{N{1'b0}}, 1'b1};

  state_t       state;
  logic [N:0]   samp_cnt;
  logic [N:0]   ones_cnt;
  logic         busy;
  logic [N-1:0] result;
  logic         result_valid;
  logic         overrun;

  logic [N:0]   samp_nx;
  logic [N:0]   ones_nx;
  logic [N-1:0] ones_sat;
  logic [N-1:0] value;

  // Counts after accepting the current bit, and the estimate they
  // would produce; a full frame of ones saturates to the top code.
  always_comb begin
    samp_nx  = samp_cnt + ONE;
    ones_nx  = ones_cnt + {{N{1'b0}}, bus.bit_in};
    ones_sat = ones_nx[N] ? {N{1'b1}} : ones_nx[N-1:0];
    value    = BIPOLAR ? (ones_sat - HALF) : ones_sat;
  end

  // Frame FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      samp_cnt     <= '0;
      ones_cnt     <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= ACCUM;
            samp_cnt <= '0;
            ones_cnt <= '0;
            overrun  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (bus.bit_valid) begin
            samp_cnt <= samp_nx;
            ones_cnt <= ones_nx;
            if (samp_nx == FRAME) begin
              state        <= HOLD;
              busy         <= 1'b0;
              result       <= value;
              result_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.bit_valid) begin
            overrun <= 1'b1;
          end
          if (bus.result_ready) begin
            result_valid <= 1'b0;
            if (bus.start) begin
              state    <= ACCUM;
              samp_cnt <= '0;
              ones_cnt <= '0;
              overrun  <= 1'b0;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.result       = result;
  assign bus.result_valid = result_valid;
  assign bus.overrun      = overrun;

endmodule
